// File: rtl/writeback_queue_if.sv
// writeback_queue_if: write-back request, register-bank drain and pending-write lookup bundle
interface writeback_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  logic [1:0]              sel;
  logic [ADDR_W-1:0]       rt_addr;
  logic [15:0]             instr_off;
  logic [ADDR_W-1:0]       alt_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_valid;
  logic                    wr_ready;
  logic                    rf_we;
  logic [ADDR_W-1:0]       rf_addr;
  logic [DATA_W-1:0]       rf_data;
  logic                    rf_ready;
  logic [ADDR_W-1:0]       q_addr;
  logic                    q_hit;
  logic [DATA_W-1:0]       q_data;
  logic [$clog2(DEPTH):0]  count;
  modport master (
    output sel, rt_addr, instr_off, alt_addr, wr_data, wr_valid, rf_ready, q_addr,
    input  wr_ready, rf_we, rf_addr, rf_data, q_hit, q_data, count
  );
  modport slave (
    input  sel, rt_addr, instr_off, alt_addr, wr_data, wr_valid, rf_ready, q_addr,
    output wr_ready, rf_we, rf_addr, rf_data, q_hit, q_data, count
  );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: destination select plus small write-back FIFO draining into the register bank,
// with a youngest-match lookup over queued entries for hazard detection and forwarding.
module writeback_queue #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int LINK_REG = 31
) (
    input logic clk,
    input logic reset,
    writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] dest;
    logic              push, pop, empty;

    always_comb begin
        dest = bus.sel == 2'b00 ? bus.rt_addr :
               bus.sel == 2'b01 ? ADDR_W'(bus.instr_off[15:11]) :
               bus.sel == 2'b10 ? bus.alt_addr : ADDR_W'(LINK_REG);
    end

    // full queue holds off writes even if the bank drains this cycle
    assign empty        = count == '0;
    assign bus.wr_ready = count != CW'(DEPTH);
    assign push         = bus.wr_valid && bus.wr_ready && dest != '0;
    assign pop          = !empty && bus.rf_ready;
    assign bus.rf_we    = !empty;
    assign bus.rf_addr  = empty ? '0 : addr_mem[rd_ptr];
    assign bus.rf_data  = empty ? '0 : data_mem[rd_ptr];
    assign bus.count    = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= pop  ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= dest;
            data_mem[wr_ptr] <= bus.wr_data;
        end
    end

    // scan oldest to youngest so the last match seen is the youngest
    always_comb begin
        bus.q_hit  = 1'b0;
        bus.q_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && bus.q_addr != '0 && addr_mem[PW'(rd_ptr + PW'(i))] == bus.q_addr) begin
                bus.q_hit  = 1'b1;
                bus.q_data = data_mem[PW'(rd_ptr + PW'(i))];
            end
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed and randomized checks of writeback_queue against a queue-based model.
module tb_writeback_queue;
    localparam int DEPTH = 4;
    logic clk = 0, reset = 1;
    int checks = 0, errors = 0;
    logic [4:0]  mq_addr[$];
    logic [31:0] mq_data[$];

    writeback_queue_if #(.ADDR_W(5), .DATA_W(32), .DEPTH(DEPTH)) bus ();
    writeback_queue #(.ADDR_W(5), .DATA_W(32), .DEPTH(DEPTH), .LINK_REG(31)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model_dest(logic [1:0] s, logic [4:0] rt, logic [15:0] io, logic [4:0] alt);
        case (s)
            2'b00:   return rt;
            2'b01:   return io[15:11];
            2'b10:   return alt;
            default: return 5'd31;
        endcase
    endfunction

    task automatic drv(input logic [1:0] s, input logic [4:0] rt, input logic [15:0] io, input logic [4:0] alt,
                       input logic [31:0] d, input logic v, input logic rr, input logic [4:0] qa);
        bus.sel = s; bus.rt_addr = rt; bus.instr_off = io; bus.alt_addr = alt;
        bus.wr_data = d; bus.wr_valid = v; bus.rf_ready = rr; bus.q_addr = qa;
    endtask

    task automatic compare_all();
        logic        hit = 0;
        logic [31:0] qd = 0;
        int n = mq_addr.size();
        for (int i = n - 1; i >= 0 && !hit; i--)
            if (bus.q_addr != 0 && mq_addr[i] == bus.q_addr) begin
                hit = 1;
                qd = mq_data[i];
            end
        chk("rf_we",    64'(bus.rf_we),    64'(n != 0));
        chk("rf_addr",  64'(bus.rf_addr),  n != 0 ? 64'(mq_addr[0]) : 64'd0);
        chk("rf_data",  64'(bus.rf_data),  n != 0 ? 64'(mq_data[0]) : 64'd0);
        chk("wr_ready", 64'(bus.wr_ready), 64'(n != DEPTH));
        chk("count",    64'(bus.count),    64'(n));
        chk("q_hit",    64'(bus.q_hit),    64'(hit));
        chk("q_data",   64'(bus.q_data),   64'(qd));
    endtask

    // called just after a falling edge with inputs already driven; returns after the next falling edge
    task automatic tick();
        logic       acc, pop;
        logic [4:0] d;
        #1 compare_all();
        acc = bus.wr_valid && mq_addr.size() < DEPTH;
        pop = mq_addr.size() > 0 && bus.rf_ready;
        d = model_dest(bus.sel, bus.rt_addr, bus.instr_off, bus.alt_addr);
        @(posedge clk);
        if (pop) begin
            void'(mq_addr.pop_front());
            void'(mq_data.pop_front());
        end
        if (acc && d != 0) begin
            mq_addr.push_back(d);
            mq_data.push_back(bus.wr_data);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1;
        mq_addr.delete();
        mq_data.delete();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 compare_all();
        do_reset();

        // decode: rt, rd field, alt, link
        for (int s = 0; s < 4; s++) begin
            drv(2'(s), 5, 16'h4800, 7, 32'h100 + 32'(s), 1, 0, 0);
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("dec_full", 64'(bus.wr_ready), 64'd0);
        for (int s = 0; s < 4; s++) begin
            logic [4:0] exp_a[4] = '{5, 9, 7, 31};
            drv(0, 0, 0, 0, 0, 0, 1, 0);
            chk("dec_addr", 64'(bus.rf_addr), 64'(exp_a[s]));
            tick();
        end

        // zero destination is dropped
        drv(0, 0, 0, 0, 32'hdead, 1, 0, 0);
        chk("zero_ready", 64'(bus.wr_ready), 64'd1);
        tick();
        chk("zero_count", 64'(bus.count), 64'd0);
        chk("zero_we", 64'(bus.rf_we), 64'd0);

        // full: 5th request held until a pop frees a slot
        for (int i = 0; i < 5; i++) begin
            drv(0, 5'(10 + i), 0, 0, 32'(i), 1, 0, 0);
            tick();
        end
        chk("full_hold", 64'(bus.count), 64'd4);
        drv(0, 14, 0, 0, 4, 1, 1, 0);
        tick();
        chk("full_pop1", 64'(bus.count), 64'd3);
        tick();
        chk("full_acc5", 64'(bus.count), 64'd3);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("full_empty", 64'(bus.count), 64'd0);

        // forwarding: youngest r8 wins
        drv(0, 8, 0, 0, 32'h11, 1, 0, 8);
        tick();
        drv(0, 8, 0, 0, 32'h22, 1, 0, 8);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 8);
        #1;
        chk("fwd_hit", 64'(bus.q_hit), 64'd1);
        chk("fwd_data", 64'(bus.q_data), 64'h22);
        bus.q_addr = 0;
        #1 chk("fwd_zero", 64'(bus.q_hit), 64'd0);
        drv(0, 0, 0, 0, 0, 0, 1, 8);
        tick();
        tick();
        chk("fwd_gone", 64'(bus.q_hit), 64'd0);
        chk("fwd_gone_d", 64'(bus.q_data), 64'd0);

        // wrap: streaming push/pop holds one entry
        for (int i = 0; i < 10; i++) begin
            drv(2, 0, 0, 5'(i + 1), 32'(i), 1, 1, 0);
            tick();
            chk("wrap_count", 64'(bus.count), 64'd1);
            chk("wrap_addr", 64'(bus.rf_addr), 64'(i + 1));
        end

        // async reset mid-cycle with 3 entries queued
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drv(0, 5'(3 + i), 0, 0, 32'(i), 1, 0, 0);
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 3);
        #2 reset = 1;
        #1;
        chk("rst_we", 64'(bus.rf_we), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_ready", 64'(bus.wr_ready), 64'd1);
        chk("rst_hit", 64'(bus.q_hit), 64'd0);
        do_reset();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drv(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 16'($urandom),
                5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
